// File: rtl/sout_drain.sv
// sout_drain: captures one row of column accumulators, requantizes each to 16 bits
// (shift, optional round-half-up, signed saturation) and streams them out one per cycle.
module sout_drain #(
  parameter int NCOL  = 4,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            shift,
  input  logic                  rnd,
  input  logic                  acc_valid,
  input  logic [NCOL*ACC_W-1:0] acc_data,
  output logic                  acc_ready,
  output logic [15:0]           s_out,
  output logic                  sat,
  output logic                  sw,
  output logic                  busy
);
  localparam int CW = $clog2(NCOL);
  localparam int VW = ACC_W + 1;
  localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

  logic [NCOL-1:0][ACC_W-1:0] cap;
  logic [4:0]                 shift_q;
  logic                       rnd_q;
  logic                       loaded;
  logic [CW-1:0]              col;
  logic [ACC_W-1:0]           sel;
  logic signed [VW-1:0]       v;
  logic signed [VW-1:0]       vs;
  logic [VW-1:0]              inc;
  logic [VW-16:0]             hi;
  logic                       in_range;
  logic [15:0]                q;

  assign acc_ready = ~start & (~loaded | (col == LAST));
  assign busy      = loaded | sw;

  // One guard bit above the accumulator keeps the rounding increment from overflowing.
  assign sel      = cap[col];
  assign v        = {sel[ACC_W-1], sel};
  assign inc      = (rnd_q && shift_q != 5'd0) ? VW'(1) << (shift_q - 5'd1) : '0;
  assign vs       = (v + $signed(inc)) >>> shift_q;
  assign hi       = vs[VW-1:15];
  assign in_range = &hi | ~|hi;
  assign q        = in_range ? vs[15:0] : (vs[VW-1] ? 16'h8000 : 16'h7fff);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap     <= '0;
      shift_q <= '0;
      rnd_q   <= 1'b0;
      loaded  <= 1'b0;
      col     <= '0;
      s_out   <= '0;
      sat     <= 1'b0;
      sw      <= 1'b0;
    end else if (start) begin
      loaded <= 1'b0;
      col    <= '0;
      sw     <= 1'b0;
    end else begin
      sw <= loaded;
      if (loaded) begin
        s_out <= q;
        sat   <= ~in_range;
        col   <= (col == LAST) ? '0 : col + 1'b1;
      end
      if (acc_valid && acc_ready) begin
        cap     <= acc_data;
        shift_q <= shift;
        rnd_q   <= rnd;
        loaded  <= 1'b1;
        col     <= '0;
      end else if (loaded && col == LAST)
        loaded <= 1'b0;
    end
endmodule

// File: tb/tb_sout_drain.sv
// tb_sout_drain: directed and random rows checked against a cycle-indexed queue of expected writes.
module tb_sout_drain;
  localparam int NCOL  = 4;
  localparam int ACC_W = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [4:0]            shift = '0;
  logic                  rnd = 1'b0;
  logic                  acc_valid = 1'b0;
  logic [NCOL*ACC_W-1:0] acc_data = '0;
  logic                  acc_ready;
  logic [15:0]           s_out;
  logic                  sat;
  logic                  sw;
  logic                  busy;

  always #5 clk = ~clk;

  sout_drain #(.NCOL(NCOL), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .rnd(rnd),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .s_out(s_out), .sat(sat), .sw(sw), .busy(busy)
  );

  typedef struct {
    int          due;
    logic [15:0] s;
    logic        st;
  } ent_t;

  ent_t        q[$];
  logic [15:0] seen_s[$];
  logic        seen_t[$];
  int          c = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_s = '0;
  logic        last_t = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic void quant(input logic [31:0] a, input int sh, input logic r,
                                output logic [15:0] s, output logic st);
    longint val;
    val = $signed(a);
    if (r && sh > 0) val = val + (longint'(1) << (sh - 1));
    val = val >>> sh;
    st = (val > 32767) || (val < -32768);
    s = (val > 32767) ? 16'h7fff : (val < -32768) ? 16'h8000 : 16'(val);
  endfunction

  function automatic logic [127:0] row(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [31:0] rval();
    int m;
    m = int'($urandom_range(0, 3));
    if (m == 0) return $urandom;
    if (m == 1) return 32'(int'($urandom_range(0, 140000)) - 70000);
    if (m == 2) return $urandom_range(0, 1) ? 32'h7fffffff : 32'h80000000;
    return 32'h1 << $urandom_range(0, 31);
  endfunction

  // One clock: check this cycle's outputs, then drive inputs sampled at the next edge.
  task automatic step(input logic v, input logic [127:0] d, input logic [4:0] sh,
                      input logic rn, input logic st);
    logic hit;
    logic rdy;
    ent_t e;
    hit = q.size() > 0 && q[0].due == c;
    if (hit) begin
      last_s = q[0].s;
      last_t = q[0].st;
      void'(q.pop_front());
    end
    chk("sw", 32'(sw), 32'(hit));
    chk("s_out", 32'(s_out), 32'(last_s));
    chk("sat", 32'(sat), 32'(last_t));
    chk("busy", 32'(busy), 32'(hit || (q.size() > 0 && q[0].due == c + 1)));
    if (sw) begin
      seen_s.push_back(s_out);
      seen_t.push_back(sat);
    end
    start = st;
    acc_valid = v;
    acc_data = d;
    shift = sh;
    rnd = rn;
    #1;
    rdy = !st && (q.size() == 0 || q[$].due <= c + 1);
    chk("acc_ready", 32'(acc_ready), 32'(rdy));
    if (st) begin
      while (q.size() > 0 && q[$].due >= c + 1) void'(q.pop_back());
    end else if (v && rdy) begin
      for (int k = 0; k < NCOL; k++) begin
        quant(d[k*ACC_W +: ACC_W], int'(sh), rn, e.s, e.st);
        e.due = c + 2 + k;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_seen(input string tag, input int off, input logic [63:0] es, input logic [3:0] et);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_s%0d", tag, k), (off + k < seen_s.size()) ? 32'(seen_s[off+k]) : 'x, 32'(es[k*16 +: 16]));
      chk($sformatf("%s_t%0d", tag, k), (off + k < seen_t.size()) ? 32'(seen_t[off+k]) : 'x, 32'(et[k]));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sw", 32'(sw), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_out", 32'(s_out), 0);
    chk("rst_ready", 32'(acc_ready), 1);
    rst_n = 1'b1;
    idle(3);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(100, -40000, 40000, -5), 5'd0, 1'b0, 1'b0);
    idle(6);
    chk("sat_count", seen_s.size(), 4);
    chk_seen("satur", 0, {16'hfffb, 16'h7fff, 16'h8000, 16'h0064}, 4'b0110);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(24, -24, 7, -8), 5'd4, 1'b1, 1'b0);
    idle(6);
    chk_seen("rnd1", 0, {16'h0000, 16'h0000, 16'hffff, 16'h0002}, 4'b0000);
    seen_s.delete(); seen_t.delete();
    step(1'b1, row(24, -24, 7, -8), 5'd4, 1'b0, 1'b0);
    idle(6);
    chk_seen("rnd0", 0, {16'hffff, 16'h0000, 16'hfffe, 16'h0001}, 4'b0000);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(1, 2, 3, 4), 5'd0, 1'b0, 1'b0);
    repeat (4) step(1'b1, row(-1, 70000, -70000, 256), 5'd0, 1'b0, 1'b0);
    idle(6);
    chk("b2b_count", seen_s.size(), 8);
    chk_seen("b2b_a", 0, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0000);
    chk_seen("b2b_b", 4, {16'h0100, 16'h8000, 16'h7fff, 16'hffff}, 4'b0110);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(10, 20, 30, 40), 5'd0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 5'd0, 1'b0, 1'b1);
    idle(3);
    chk("abort_count", seen_s.size(), 2);
    step(1'b1, row(5, 6, 7, 8), 5'd0, 1'b0, 1'b0);
    idle(6);
    chk("abort_new_count", seen_s.size(), 6);
    chk_seen("abort_new", 2, {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 4'b0000);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(32'h1200, 32'h3400, -32'h800000, 32'h800000), 5'd8, 1'b0, 1'b0);
    idle(6);
    chk_seen("cfg", 0, {16'h7fff, 16'h8000, 16'h0034, 16'h0012}, 4'b1000);

    seen_s.delete(); seen_t.delete();
    step(1'b1, row(11, 12, 13, 14), 5'd0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, '0, 5'd0, 1'b0, 1'b1);
    idle(3);
    chk("start_last_count", seen_s.size(), 3);

    step(1'b1, row(-3, -4, -5, -6), 5'd0, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sw", 32'(sw), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_s_out", 32'(s_out), 0);
    chk("mid_rst_sat", 32'(sat), 0);
    chk("mid_rst_ready", 32'(acc_ready), 1);
    q.delete();
    last_s = '0;
    last_t = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 400; i++) begin
      logic [127:0] d;
      logic [4:0]   sh;
      for (int k = 0; k < NCOL; k++) d[k*ACC_W +: ACC_W] = rval();
      sh = $urandom_range(0, 1) ? 5'($urandom_range(0, 8)) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, d, sh, 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sout_drain.md
# sout_drain

Output drain stage between the systolic array's accumulator row and the output store buffer. It captures one row of wide signed column accumulators at a time, requantizes each to 16 bits (arithmetic right shift, optional rounding, signed saturation), and serializes them one per cycle onto the `s_out`/`sat`/`sw` write stream. The store buffer counts `sw` strobes to track run progress and packs `sat` flags.

## Interface
Parameters:
- `NCOL`, 4: number of array columns per captured row (≥2).
- `ACC_W`, 32: accumulator width, signed two's complement (≥17).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run start / abort pulse; synchronous clear of drain state.
- `shift`  in  5  right-shift amount 0..31 applied before saturation.
- `rnd`  in  1  1 = round half up (add 2^(shift-1) before shift when shift>0).
- `acc_valid`  in  1  row present on `acc_data`.
- `acc_data`  in  NCOL*ACC_W  column c at bits [c*ACC_W +: ACC_W].
- `acc_ready`  out  1  row accepted on cycles where `acc_valid & acc_ready`.
- `s_out`  out  16  requantized signed result.
- `sat`  out  1  1 = `s_out` was clamped.
- `sw`  out  1  write strobe; `s_out`/`sat` valid this cycle.
- `busy`  out  1  row held or strobe in flight.

## Operation
- State: capture register CAP (NCOL×ACC_W), captured `shift_q`/`rnd_q`, `loaded` flag, column counter `col` (log2 NCOL bits), registered outputs `s_out`/`sat`/`sw`.
- `acc_ready = ~start & (~loaded | (col == NCOL-1))` (combinational). A new row can be accepted on the cycle the last column of the current row is issued, so bursts have no gaps.
- On handshake: CAP <= `acc_data`, `shift_q` <= `shift`, `rnd_q` <= `rnd`, `loaded` <= 1, `col` <= 0. `shift`/`rnd` changes during a row do not affect that row.
- Each cycle with `loaded`: select CAP[col], quantize, register the result into `s_out`/`sat` with `sw` = 1. `col` increments. After col NCOL-1: `loaded` <= 0 unless a new handshake occurs in the same cycle.
- Column order: column 0 first, column NCOL-1 last.
- Quantize, on an (ACC_W+1)-bit signed value v = sign-extended CAP[col]:
  - If `rnd_q` and `shift_q` > 0: v += 1 << (shift_q-1).
  - v >>>= `shift_q`.
  - If v > 32767: `s_out` = 16'h7FFF, `sat` = 1.
  - If v < -32768: `s_out` = 16'h8000, `sat` = 1.
  - Otherwise `s_out` = v[15:0], `sat` = 0.
- `start`: `loaded` <= 0, `col` <= 0, `sw` <= 0 next cycle. A row in flight is dropped. `acc_valid` in the `start` cycle is ignored.
- When `sw` = 0, `s_out` and `sat` hold their last values.
- `busy = loaded | sw`.

## Timing
- Reset values: `s_out` = 0, `sat` = 0, `sw` = 0, `busy` = 0, `acc_ready` = 1 (with `start` low). CAP, `col` and `loaded` are all cleared.
- Handshake in cycle T: column k appears with `sw` = 1 in cycle T+2+k, for k = 0..NCOL-1.
- Continuous `acc_valid`: one row per NCOL cycles and `sw` stays high without gaps. `acc_ready` is low for NCOL-1 cycles of each row.
- Reset asserted mid-row: all state clears immediately and no further `sw` is produced.
- `start` together with the last-column issue: that column's `sw` is suppressed (`start` wins).
- No backpressure from downstream; the store buffer must accept one write per cycle.

## Test plan
- Reset: hold `rst_n` = 0 → `sw`/`sat`/`busy` = 0, `s_out` = 0, `acc_ready` = 1. Release with no traffic → all remain unchanged.
- Saturation: NCOL=4, shift=0, rnd=0, row {c0=100, c1=-40000, c2=40000, c3=-5} accepted at T → `sw` high T+2..T+5 with `s_out` = 0x0064/0x8000/0x7FFF/0xFFFB and `sat` = 0/1/1/0. `busy` low at T+6.
- Rounding: shift=4, row {24, -24, 7, -8}. With rnd=1 → `s_out` = 2, -1 (0xFFFF), 0, 0. With rnd=0 → 1, -2 (0xFFFE), 0, -1 (0xFFFF). All `sat` = 0.
- Back-to-back: `acc_valid` held high with rows A and B → exactly 8 consecutive `sw` cycles, A0..A3 then B0..B3. `acc_ready` is high only in the cycles of the two handshakes (T and T+4). No third row is accepted while `acc_valid` is dropped after B.
- Abort: `start` pulsed in the cycle after the 2nd `sw` of a row → exactly 2 strobes for that row, `sw` = 0 next cycle, `busy` = 0, `acc_ready` = 1 afterwards. A new row then drains normally from column 0.
- Config stability: row accepted with shift=8, then `shift` changed to 0 after the handshake → all 4 columns use shift 8 (e.g. 0x1200 → 0x0012).
